freq_to_ctl: RTL

FREQ_TO_CTL -- requirements
Module: freq_to_ctl

---
 rtl/freq_to_ctl.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/freq_to_ctl.sv
// freq_to_ctl: converts a four-digit BCD frequency in Hz into a 12-bit DDS
// frequency control word, freq_ctl = F*4096/10000.
//
// Operation: IDLE latches and validates the digits, CONV accumulates the
// binary value F over four cycles (thousands first), DIV runs a 26-step
// restoring division of F<<12 by 10000, and DONE loads the result and pulses
// done.  Any non-BCD digit takes IDLE straight to DONE with err set and the
// previous freq_ctl preserved.
//
// Build option: define FREQ_TO_CTL_ROUND_EN to add 5000 to the dividend
// (round-half-up).  Without it the quotient is truncated.  Latency is the same
// in both builds, and quotients above 4095 saturate to 4095.

module freq_to_ctl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  thou_digit,
  input  logic [3:0]  hund_digit,
  input  logic [3:0]  ten_digit,
  input  logic [3:0]  one_digit,
  output logic [11:0] freq_ctl,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // ---------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------
  localparam int          NUM_DIGITS = 4;
  localparam int          DVD_W      = 26;
  localparam logic [14:0] DIVISOR    = 15'd10000;
  localparam logic [1:0]  CONV_LAST  = 2'd3;
  localparam logic [4:0]  DIV_LAST   = 5'd25;

`ifdef FREQ_TO_CTL_ROUND_EN
  // Half the divisor added up front turns the floor division into round-half-up.
  localparam logic [DVD_W-1:0] ROUND_ADD = 26'd5000;
`else
  localparam logic [DVD_W-1:0] ROUND_ADD = 26'd0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_t            state_reg;
  state_t            state_next;

  logic [15:0]       digits_reg;     // {thou, hund, ten, one} captured at start
  logic              err_reg;
  logic [1:0]        conv_cnt_reg;
  logic [13:0]       acc_reg;        // running binary value of F
  logic [4:0]        div_cnt_reg;
  logic [13:0]       rem_reg;        // partial remainder, always < 10000
  logic [DVD_W-1:0]  quo_reg;        // dividend shifts out the top, quotient in
  logic [11:0]       freq_reg;
  logic              done_reg;

  // ---------------------------------------------------------------------
  // Digit validation (on the live inputs, used when start is sampled)
  // ---------------------------------------------------------------------
  logic [15:0]           digits_in;
  logic [NUM_DIGITS-1:0] digit_ok;
  logic                  digits_bad;

  assign digits_in = {thou_digit, hund_digit, ten_digit, one_digit};

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_chk
      assign digit_ok[gi] = (digits_in[gi*4 +: 4] <= 4'd9);
    end
  endgenerate

  assign digits_bad = ~(&digit_ok);

  // ---------------------------------------------------------------------
  // Conversion step: acc*10 + current digit, thousands digit first
  // ---------------------------------------------------------------------
  logic [3:0]       cur_digit;
  logic [13:0]      acc_next;
  logic [DVD_W-1:0] dividend_init;

  // Pick the digit for this CONV cycle out of the latched copy.
  always_comb begin
    cur_digit = 4'd0;
    case (conv_cnt_reg)
      2'd0:    cur_digit = digits_reg[15:12];
      2'd1:    cur_digit = digits_reg[11:8];
      2'd2:    cur_digit = digits_reg[7:4];
      default: cur_digit = digits_reg[3:0];
    endcase
  end

  // F never exceeds 9999, so 14 bits hold every intermediate value.
  assign acc_next      = acc_reg * 14'd10 + {10'd0, cur_digit};
  // Largest dividend is 9999*4096 + 5000, comfortably below 2**26.
  assign dividend_init = {acc_next, 12'd0} + ROUND_ADD;

  // ---------------------------------------------------------------------
  // Restoring division step: one quotient bit per cycle
  // ---------------------------------------------------------------------
  logic [14:0]      trial;
  logic             trial_ge;
  logic [13:0]      trial_diff;
  logic [13:0]      rem_new;
  logic [DVD_W-1:0] quo_new;
  logic [11:0]      quo_sat;

  assign trial      = {rem_reg, quo_reg[DVD_W-1]};
  assign trial_ge   = (trial >= DIVISOR);
  assign trial_diff = 14'(trial - DIVISOR);
  assign rem_new    = trial_ge ? trial_diff : trial[13:0];
  assign quo_new    = {quo_reg[DVD_W-2:0], trial_ge};

  // Any quotient bit above bit 11 means the word would exceed 4095: clamp.
  assign quo_sat    = (|quo_reg[DVD_W-1:12]) ? 12'hFFF : quo_reg[11:0];

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = digits_bad ? DONE : CONV;
        end
      end
      CONV: begin
        if (conv_cnt_reg == CONV_LAST) begin
          state_next = DIV;
        end
      end
      DIV: begin
        if (div_cnt_reg == DIV_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  // Capture the request; digits may change freely once this has happened.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_reg <= 16'd0;
      err_reg    <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      digits_reg <= digits_in;
      err_reg    <= digits_bad;
    end
  end

  // Accumulate F over the four CONV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_cnt_reg <= 2'd0;
      acc_reg      <= 14'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          conv_cnt_reg <= 2'd0;
          acc_reg      <= 14'd0;
        end
        CONV: begin
          conv_cnt_reg <= conv_cnt_reg + 2'd1;
          acc_reg      <= acc_next;
        end
        default: begin
          conv_cnt_reg <= conv_cnt_reg;
          acc_reg      <= acc_reg;
        end
      endcase
    end
  end

  // Divider: seeded on the last CONV cycle so DIV spends exactly 26 cycles
  // producing quotient bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= 5'd0;
      rem_reg     <= 14'd0;
      quo_reg     <= '0;
    end else begin
      case (state_reg)
        CONV: begin
          if (conv_cnt_reg == CONV_LAST) begin
            div_cnt_reg <= 5'd0;
            rem_reg     <= 14'd0;
            quo_reg     <= dividend_init;
          end
        end
        DIV: begin
          div_cnt_reg <= div_cnt_reg + 5'd1;
          rem_reg     <= rem_new;
          quo_reg     <= quo_new;
        end
        default: begin
          div_cnt_reg <= div_cnt_reg;
          rem_reg     <= rem_reg;
          quo_reg     <= quo_reg;
        end
      endcase
    end
  end

  // Result register and completion pulse; the error path keeps the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_reg <= 12'd0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= (state_reg == DONE);
      if (state_reg == DONE && !err_reg) begin
        freq_reg <= quo_sat;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign freq_ctl = freq_reg;
  assign done     = done_reg;
  assign err      = err_reg;
  assign busy     = (state_reg == CONV) || (state_reg == DIV);

endmodule
